butterfly_recombine_unit: RTL and testbench
===========================================

# butterfly_recombine_unit

Streaming inverse of the team's radix-2 scaled butterfly: takes a butterfly output pair (C1, C2) of packed complex samples and reconstructs A = C1 + C2 and B = C1 − C2. Each component is either saturated or halved, selected per beat. It sits on the synthesis/IFFT side of the datapath, downstream of a stage that produces butterfly pairs. The block uses a two-stage, fully backpressured valid/ready pipeline and keeps a saturating event counter.

## Interface
- Parameters
  - W, default 12: component width; samples are 2W bits, real part in [2W-1:W], imaginary part in [W-1:0], two's complement.
- Ports
  - clk  in  1  sole clock, rising edge.
  - reset  in  1  synchronous reset, active-high.
  - in_valid  in  1  input beat present.
  - in_ready  out  1  block accepts a beat this cycle.
  - in_c1  in  2W  butterfly sum sample.
  - in_c2  in  2W  butterfly difference sample.
  - in_div2  in  1  per-beat mode: 1 = halve results, 0 = saturate.
  - out_valid  out  1  output beat present.
  - out_ready  in  1  downstream accepts.
  - out_a  out  2W  recombined A.
  - out_b  out  2W  recombined B.
  - out_sat  out  1  at least one of the 4 components of this beat clipped.
  - sat_count  out  8  count of saturated beats, sticks at 255.
  - sat_clr  in  1  clears sat_count.

## Operation
- Handshakes:
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
- Stage 1 (S1) registers in_c1, in_c2, and in_div2 on input transfer. The mode bit travels with its data.
- Arithmetic is per component (re, im independently), computed from S1 contents:
  - sum = sext(c1) + sext(c2), 13 bits for W = 12; diff = sext(c1) − sext(c2).
  - div2 = 1: result = bits [W:1] of the (W+1)-bit value, i.e. an arithmetic shift that rounds toward −∞. Never clips.
  - div2 = 0: clamp to [−2^(W−1), 2^(W−1)−1]. Any clamp on any of the 4 components sets sat for that beat.
- Stage 2 (S2) registers out_a, out_b, and out_sat.
  - S2 loads when S1 is valid and S2 can take a beat: !out_valid || out_ready.
- Ready/flow:
  - in_ready = !s1_valid || (S2 can take a beat). Combinational, with no combinational path from in_valid.
  - Capacity is 2 beats. Order is preserved; there is no loss or duplication.
  - Output data holds stable while out_valid && !out_ready.
- sat_count:
  - Increments by 1 when a beat with sat = 1 loads into S2. Holds at 255.
  - sat_clr has priority: if clear and increment coincide, the result is 0.
- Reset values: out_valid 0, s1_valid 0, out_a 0, out_b 0, out_sat 0, sat_count 0. in_ready reads 1 in the first cycle after reset.
- Reset mid-stream discards all in-flight beats. Any input transfer in the reset cycle is ignored.

## Timing
- Latency: an input accepted at edge k gives out_valid high after edge k+1 when unstalled. That is 2 register stages, so the beat appears 1 cycle after the accept edge, 2 edges after the input was presented.
- Throughput: 1 beat/cycle with out_ready held high.
- Stall: with out_ready low, the block accepts at most 2 beats, then in_ready = 0. When out_ready rises, in_ready rises in the same cycle.
- sat_count updates on the same edge the saturated beat loads into S2. sat_clr takes effect on the next edge.
- All outputs are registered except in_ready.

## Test plan
- Basic, div2 = 0: C1 = {100, 50}, C2 = {20, −10} (0xFF6) -> A = {0x078, 0x028}, B = {0x050, 0x03C}, out_sat = 0; output appears 1 cycle after accept.
- Saturation: C1 = {2000, −2048}, C2 = {100, 1} -> A = {0x7FF, 0x801}, B = {0x76C, 0x800}, out_sat = 1, sat_count = 1.
- Halving, div2 = 1: C1 = {2000, −3}, C2 = {100, 0} -> A = {0x41A, 0xFFE}, B = {0x3B6, 0xFFE}, out_sat = 0, sat_count unchanged.
- Backpressure: 6 back-to-back beats, out_ready low for 4 cycles mid-stream -> in_ready falls after 2 buffered beats; all 6 outputs arrive in order with correct values; out_a/out_b stable while stalled.
- Counter: 260 saturating beats -> sat_count = 255 held. Then sat_clr in the same cycle as a saturated beat loading into S2 -> sat_count = 0.
- Reset mid-stream: reset while 2 beats are in flight -> next cycle out_valid = 0, sat_count = 0, in_ready = 1. The first post-reset beat emerges alone with correct values.

Source files
------------

// File: rtl/butterfly_recombine_unit.sv
// Recombines a radix-2 butterfly output pair into A = C1 + C2 and B = C1 - C2.
// Each component is either saturated or halved. The pipeline has two stages with valid/ready handshaking.
module butterfly_recombine_unit #(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_c1,
  input  logic [2*W-1:0] in_c2,
  input  logic           in_div2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_a,
  output logic [2*W-1:0] out_b,
  output logic           out_sat,
  output logic [7:0]     sat_count,
  input  logic           sat_clr
);

  logic           s1_valid;
  logic [2*W-1:0] s1_c1;
  logic [2*W-1:0] s1_c2;
  logic           s1_div2;
  logic           s2_take;
  logic           s2_load;
  logic [W:0]     a_re, a_im, b_re, b_im;
  logic           beat_sat;

  // The result holds a clip flag in bit W and the W-bit component below it.
  function automatic logic [W:0] recombine(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sub, input logic div2);
    logic [W:0] r;
    logic [W:0] res;
    r = sub ? ({x[W-1], x} - {y[W-1], y}) : ({x[W-1], x} + {y[W-1], y});
    if (div2)
      res = {1'b0, r[W:1]};
    else if (r[W] != r[W-1])
      res = {1'b1, (r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})};
    else
      res = {1'b0, r[W-1:0]};
    return res;
  endfunction

  always_comb begin
    a_re = recombine(s1_c1[2*W-1:W], s1_c2[2*W-1:W], 1'b0, s1_div2);
    a_im = recombine(s1_c1[W-1:0],   s1_c2[W-1:0],   1'b0, s1_div2);
    b_re = recombine(s1_c1[2*W-1:W], s1_c2[2*W-1:W], 1'b1, s1_div2);
    b_im = recombine(s1_c1[W-1:0],   s1_c2[W-1:0],   1'b1, s1_div2);
    beat_sat = a_re[W] | a_im[W] | b_re[W] | b_im[W];
  end

  assign s2_take  = !out_valid || out_ready;
  assign s2_load  = s1_valid && s2_take;
  assign in_ready = !s1_valid || s2_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_c1    <= '0;
      s1_c2    <= '0;
      s1_div2  <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_c1    <= in_c1;
      s1_c2    <= in_c2;
      s1_div2  <= in_div2;
    end else if (s2_take) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sat   <= 1'b0;
    end else if (s2_take) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_a   <= {a_re[W-1:0], a_im[W-1:0]};
        out_b   <= {b_re[W-1:0], b_im[W-1:0]};
        out_sat <= beat_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || sat_clr)
      sat_count <= '0;
    else if (s2_load && beat_sat && sat_count != 8'hFF)
      sat_count <= sat_count + 8'd1;
  end

endmodule

// File: tb/tb_butterfly_recombine_unit.sv
// Scoreboard bench for butterfly_recombine_unit.
// Expected beats are queued when an input is accepted and checked when the output is presented.
module tb_butterfly_recombine_unit;
  localparam int W = 12;

  typedef struct packed {
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
    logic           sat;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] in_c1 = '0;
  logic [2*W-1:0] in_c2 = '0;
  logic           in_div2 = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] out_a;
  logic [2*W-1:0] out_b;
  logic           out_sat;
  logic [7:0]     sat_count;
  logic           sat_clr = 1'b0;

  int   n_vec = 0;
  int   n_miss = 0;
  exp_t q[$];

  butterfly_recombine_unit #(.W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_c1(in_c1), .in_c2(in_c2), .in_div2(in_div2),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_sat(out_sat), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on plain integers: floor halving and explicit clamp.
  function automatic int comp(input int x, input int y, input bit sub, input bit div2,
                              inout bit sat);
    int r;
    int lim;
    lim = 1 << (W - 1);
    r = sub ? x - y : x + y;
    if (div2) r = r >>> 1;
    else if (r > lim - 1) begin r = lim - 1; sat = 1'b1; end
    else if (r < -lim) begin r = -lim; sat = 1'b1; end
    return r;
  endfunction

  function automatic exp_t model(input int c1r, input int c1i, input int c2r, input int c2i,
                                 input bit div2);
    exp_t e;
    bit s;
    int ar, ai, br, bi;
    s  = 1'b0;
    ar = comp(c1r, c2r, 1'b0, div2, s);
    ai = comp(c1i, c2i, 1'b0, div2, s);
    br = comp(c1r, c2r, 1'b1, div2, s);
    bi = comp(c1i, c2i, 1'b1, div2, s);
    e.a   = {ar[W-1:0], ai[W-1:0]};
    e.b   = {br[W-1:0], bi[W-1:0]};
    e.sat = s;
    return e;
  endfunction

  // Returns at posedge+1 of the accepting edge; in_valid is left low.
  task automatic send(input int c1r, input int c1i, input int c2r, input int c2i, input bit div2);
    int tries;
    in_c1    = {c1r[W-1:0], c1i[W-1:0]};
    in_c2    = {c2r[W-1:0], c2i[W-1:0]};
    in_div2  = div2;
    in_valid = 1'b1;
    tries = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      tries++;
      if (tries > 100) begin
        chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    q.push_back(model(c1r, c1i, c2r, c2i, div2));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'd1, 64'd0);
      end else begin
        chk("out_a", 64'(out_a), 64'(q[0].a));
        chk("out_b", 64'(out_b), 64'(q[0].b));
        chk("out_sat", 64'(out_sat), 64'(q[0].sat));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_a", 64'(out_a), 64'd0);
    chk("rst_out_b", 64'(out_b), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_sat_count", 64'(sat_count), 64'd0);

    // Basic beat with latency check
    send(100, 50, 20, -10, 1'b0);
    chk("lat_s1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_s2", 64'(out_valid), 64'd1);
    chk("basic_a", 64'(out_a), 64'h078028);
    chk("basic_b", 64'(out_b), 64'h05003C);
    drain();

    send(2000, -2048, 100, 1, 1'b0);
    drain();
    @(posedge clk); #1;
    chk("sat_count_1", 64'(sat_count), 64'd1);
    chk("sat_vec_a", 64'(out_a), 64'h7FF801);
    chk("sat_vec_b", 64'(out_b), 64'h76C800);

    send(2000, -3, 100, 0, 1'b1);
    drain();
    @(posedge clk); #1;
    chk("half_vec_a", 64'(out_a), 64'h41AFFE);
    chk("half_vec_b", 64'(out_b), 64'h3B6FFE);
    chk("sat_count_hold", 64'(sat_count), 64'd1);

    // Stall: two beats fill the pipe, then in_ready drops until out_ready rises
    out_ready = 1'b0;
    send(1, 2, 3, 4, 1'b0);
    send(-5, 6, 7, -8, 1'b1);
    chk("stall_full", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("stall_hold", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1 chk("stall_release", 64'(in_ready), 64'd1);
    drain();

    fork
      begin
        for (int i = 0; i < 6; i++)
          send(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
               int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
               1'($urandom_range(1)));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Counter saturation, then clear coinciding with a saturated beat entering S2
    for (int i = 0; i < 260; i++) send(2000, -2048, 100, 1, 1'b0);
    drain();
    @(posedge clk); #1;
    chk("sat_count_255", 64'(sat_count), 64'd255);
    send(2000, -2048, 100, 1, 1'b0);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr_beat_valid", 64'(out_valid), 64'd1);
    chk("clr_priority", 64'(sat_count), 64'd0);
    drain();

    // Reset with two saturated beats in flight
    out_ready = 1'b0;
    send(2000, -2048, 100, 1, 1'b0);
    send(2000, -2048, 100, 1, 1'b0);
    chk("pre_rst_count", 64'(sat_count), 64'd1);
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(sat_count), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(100, 50, 20, -10, 1'b0);
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
